// File: rtl/exmem_arb_pkg.sv
// Shared types and constants for the exmem_arb shared-BRAM arbiter.
// Build option: define EXMEM_ARB_RR_EN for round-robin tie breaking,
// leave it undefined for fixed Wishbone-first priority.
package exmem_arb_pkg;

  // Transaction FSM states
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  // Requester identity; also the encoding of grant_o
  typedef enum logic {
    REQ_WB = 1'b0,
    REQ_LA = 1'b1
  } req_id_e;

  // Wishbone address window (adr[31:24]) that maps onto the BRAM
  localparam logic [7:0] USER_BASE = 8'h38;

endpackage

// File: rtl/exmem_arb_pick.sv
// Tie resolution between the Wishbone and LA requesters.
// With EXMEM_ARB_RR_EN defined, a tie goes to the requester that was not
// granted last; otherwise Wishbone always wins a tie.
module exmem_arb_pick
  import exmem_arb_pkg::*;
(
  input  logic    wb_valid_i,
  input  logic    la_valid_i,
  input  req_id_e last_grant_i,
  output req_id_e grant_o
);

`ifdef EXMEM_ARB_RR_EN
  // Round-robin: on a tie, hand the grant to the other requester
  always_comb begin
    grant_o = REQ_WB;
    if (wb_valid_i && la_valid_i) begin
      grant_o = (last_grant_i == REQ_LA) ? REQ_WB : REQ_LA;
    end else if (la_valid_i) begin
      grant_o = REQ_LA;
    end
  end
`else
  // Fixed priority does not need the history
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;

  // Fixed priority: Wishbone wins whenever it is requesting
  always_comb begin
    grant_o = REQ_WB;
    if (!wb_valid_i && la_valid_i) begin
      grant_o = REQ_LA;
    end
  end
`endif

endmodule

// File: rtl/exmem_arb.sv
// exmem_arb: arbitrates a Wishbone slave port and an LA requester onto one
// single-port BRAM (one-cycle read latency), inserting DELAYS wait states
// before every access.
// Build option: EXMEM_ARB_RR_EN selects round-robin tie breaking.
//
// Handshake: a requester raises its request (WB: cyc&stb in the BRAM window,
// LA: la_req_i) and holds it until its ack. The request is sampled once in
// IDLE; later changes to address/data are ignored. The ack is a single-cycle
// pulse DELAYS+2 cycles after the sampling cycle, with read data valid in the
// same cycle and held afterwards. A WB requester that drops cyc/stb before
// the response gets no ack, but the memory cycle still completes.
module exmem_arb
  import exmem_arb_pkg::*;
#(
  parameter int DELAYS = 10,
  parameter int AW     = 10
) (
  input  logic          wb_clk_i,
  input  logic          wb_rstn_i,
  // Wishbone slave
  input  logic          wbs_cyc_i,
  input  logic          wbs_stb_i,
  input  logic          wbs_we_i,
  input  logic [3:0]    wbs_sel_i,
  input  logic [31:0]   wbs_adr_i,
  input  logic [31:0]   wbs_dat_i,
  output logic          wbs_ack_o,
  output logic [31:0]   wbs_dat_o,
  // LA requester
  input  logic          la_req_i,
  input  logic          la_we_i,
  input  logic [AW-1:0] la_adr_i,
  input  logic [31:0]   la_dat_i,
  output logic          la_ack_o,
  output logic [31:0]   la_dat_o,
  // BRAM port
  output logic          mem_en_o,
  output logic [3:0]    mem_we_o,
  output logic [AW-1:0] mem_adr_o,
  output logic [31:0]   mem_wdat_o,
  input  logic [31:0]   mem_rdat_i,
  // Status
  output logic          busy_o,
  output logic          grant_o,
  output state_e        dbg_state_o
);

  localparam int CW = (DELAYS > 1) ? $clog2(DELAYS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((DELAYS > 0) ? DELAYS - 1 : 0);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  req_id_e       who_q;
  req_id_e       grant_q;
  logic          we_q;
  logic [AW-1:0] adr_q;
  logic [31:0]   wdat_q;
  logic [3:0]    mask_q;
  logic          wb_abort_q;
  logic          mem_en_q;
  logic [3:0]    mem_we_q;
  logic          wb_ack_q;
  logic          la_ack_q;
  logic [31:0]   wb_dat_q;
  logic [31:0]   la_dat_q;

  logic          wb_live;
  logic          wb_valid;
  logic          la_valid;
  req_id_e       pick_id;
  logic          nx_we;
  logic [AW-1:0] nx_adr;
  logic [31:0]   nx_wdat;
  logic [3:0]    nx_mask;

  // Only adr[AW+1:2] addresses the BRAM; the rest is window decode or ignored
  logic unused_adr;
  assign unused_adr = ^{wbs_adr_i[23:AW+2], wbs_adr_i[1:0]};

  assign wb_live  = wbs_cyc_i & wbs_stb_i;
  assign wb_valid = wb_live && (wbs_adr_i[31:24] == USER_BASE);
  assign la_valid = la_req_i;

  exmem_arb_pick u_pick (
    .wb_valid_i   (wb_valid),
    .la_valid_i   (la_valid),
    .last_grant_i (grant_q),
    .grant_o      (pick_id)
  );

  // Transaction fields of whichever requester wins this IDLE cycle
  always_comb begin
    nx_we   = wbs_we_i;
    nx_adr  = wbs_adr_i[AW+1:2];
    nx_wdat = wbs_dat_i;
    nx_mask = wbs_sel_i;
    if (pick_id == REQ_LA) begin
      nx_we   = la_we_i;
      nx_adr  = la_adr_i;
      nx_wdat = la_dat_i;
      nx_mask = 4'hF;
    end
  end

  // Transaction FSM with registered strobes, acks and held read data
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      who_q      <= REQ_WB;
      grant_q    <= REQ_LA;
      we_q       <= 1'b0;
      adr_q      <= '0;
      wdat_q     <= '0;
      mask_q     <= '0;
      wb_abort_q <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= '0;
      wb_ack_q   <= 1'b0;
      la_ack_q   <= 1'b0;
      wb_dat_q   <= '0;
      la_dat_q   <= '0;
    end else begin
      mem_en_q <= 1'b0;
      mem_we_q <= '0;
      wb_ack_q <= 1'b0;
      la_ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (wb_valid || la_valid) begin
            grant_q    <= pick_id;
            who_q      <= pick_id;
            we_q       <= nx_we;
            adr_q      <= nx_adr;
            wdat_q     <= nx_wdat;
            mask_q     <= nx_mask;
            wb_abort_q <= 1'b0;
            cnt_q      <= '0;
            if (DELAYS == 0) begin
              state_q  <= S_ACCESS;
              mem_en_q <= 1'b1;
              mem_we_q <= nx_we ? nx_mask : 4'h0;
            end else begin
              state_q  <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (who_q == REQ_WB && !wb_live) wb_abort_q <= 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q  <= S_ACCESS;
            mem_en_q <= 1'b1;
            mem_we_q <= we_q ? mask_q : 4'h0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_ACCESS: begin
          state_q  <= S_RESP;
          la_ack_q <= (who_q == REQ_LA);
          wb_ack_q <= (who_q == REQ_WB) && !wb_abort_q && wb_live;
        end
        S_RESP: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          if (!we_q && la_ack_q) la_dat_q <= mem_rdat_i;
          if (!we_q && wb_ack_q) wb_dat_q <= mem_rdat_i;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Read data is presented straight from the BRAM during the ack cycle
  assign wbs_dat_o  = (state_q == S_RESP && wb_ack_q && !we_q) ? mem_rdat_i : wb_dat_q;
  assign la_dat_o   = (state_q == S_RESP && la_ack_q && !we_q) ? mem_rdat_i : la_dat_q;

  assign wbs_ack_o   = wb_ack_q;
  assign la_ack_o    = la_ack_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_adr_o   = adr_q;
  assign mem_wdat_o  = wdat_q;
  assign busy_o      = (state_q != S_IDLE);
  assign grant_o     = grant_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_exmem_arb.sv
// Self-checking bench for exmem_arb: directed scenarios followed by random
// transactions, checked against a transaction-level model of the BRAM
// contents, arbitration order and response timing.
module tb_exmem_arb;
  import exmem_arb_pkg::*;

  localparam int DELAYS = 10;
  localparam int AW     = 10;
  localparam int LAT    = DELAYS + 2;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          wbs_cyc, wbs_stb, wbs_we, wbs_ack;
  logic [3:0]    wbs_sel;
  logic [31:0]   wbs_adr, wbs_dat, wbs_rdat;
  logic          la_req, la_we, la_ack;
  logic [AW-1:0] la_adr;
  logic [31:0]   la_dat, la_rdat;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_adr;
  logic [31:0]   mem_wdat, mem_rdat;
  logic          busy, grant;
  state_e        dbg_state;

  exmem_arb #(.DELAYS(DELAYS), .AW(AW)) dut (
    .wb_clk_i    (clk),
    .wb_rstn_i   (rst_n),
    .wbs_cyc_i   (wbs_cyc),
    .wbs_stb_i   (wbs_stb),
    .wbs_we_i    (wbs_we),
    .wbs_sel_i   (wbs_sel),
    .wbs_adr_i   (wbs_adr),
    .wbs_dat_i   (wbs_dat),
    .wbs_ack_o   (wbs_ack),
    .wbs_dat_o   (wbs_rdat),
    .la_req_i    (la_req),
    .la_we_i     (la_we),
    .la_adr_i    (la_adr),
    .la_dat_i    (la_dat),
    .la_ack_o    (la_ack),
    .la_dat_o    (la_rdat),
    .mem_en_o    (mem_en),
    .mem_we_o    (mem_we),
    .mem_adr_o   (mem_adr),
    .mem_wdat_o  (mem_wdat),
    .mem_rdat_i  (mem_rdat),
    .busy_o      (busy),
    .grant_o     (grant),
    .dbg_state_o (dbg_state)
  );

  // BRAM with byte enables and one-cycle read latency
  bit [31:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_adr][8*b +: 8] <= mem_wdat[8*b +: 8];
      mem_rdat <= ram[mem_adr];
    end
  end

  // ---------------- scoreboard / model ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  bit [31:0]   shadow [0:(1<<AW)-1];
  logic [31:0] exp_q[$];
  logic [31:0] exp_wb_dat = '0;
  logic [31:0] exp_la_dat = '0;
  bit          last_la    = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one access to the model memory; returns the read value for reads
  function automatic logic [31:0] model_acc(input bit we, input int a,
                                            input logic [31:0] d, input logic [3:0] m);
    logic [31:0] v;
    v = shadow[a];
    if (we) begin
      for (int b = 0; b < 4; b++)
        if (m[b]) shadow[a][8*b +: 8] = d[8*b +: 8];
    end
    return v;
  endfunction

  // ---------------- driver / monitor ----------------
  int          r_wb_ack, r_la_ack, r_wb_acks, r_la_acks, r_stray;
  logic [31:0] r_wb_rd, r_la_rd;
  bit          r_busy;
  int          en_cyc[$];
  logic [3:0]  en_we[$];
  logic [AW-1:0] en_adr[$];

  task automatic idle_inputs();
    wbs_cyc = 0; wbs_stb = 0; wbs_we = 0; wbs_sel = 0; wbs_adr = 0; wbs_dat = 0;
    la_req = 0; la_we = 0; la_adr = 0; la_dat = 0;
  endtask

  // Called #1 after a posedge; observes cycles 0..budget-1 at the negedge
  task automatic run(input bit do_wb, input bit wb_we, input logic [31:0] wb_adr,
                     input logic [31:0] wb_dat, input logic [3:0] wb_sel,
                     input bit do_la, input bit la_w, input logic [AW-1:0] la_a,
                     input logic [31:0] la_d, input int drop_wb_at, input int budget);
    bit wb_pend, la_pend, scramble;
    r_wb_ack = -1; r_la_ack = -1; r_wb_acks = 0; r_la_acks = 0; r_stray = 0;
    r_wb_rd = 'x; r_la_rd = 'x; r_busy = 0;
    en_cyc.delete(); en_we.delete(); en_adr.delete();
    wb_pend = do_wb; la_pend = do_la; scramble = do_wb ^ do_la;
    if (do_wb) begin
      wbs_cyc = 1; wbs_stb = 1; wbs_we = wb_we; wbs_adr = wb_adr; wbs_dat = wb_dat; wbs_sel = wb_sel;
    end
    if (do_la) begin
      la_req = 1; la_we = la_w; la_adr = la_a; la_dat = la_d;
    end
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (wbs_ack) begin r_wb_ack = n; r_wb_acks++; r_wb_rd = wbs_rdat; end
      if (la_ack)  begin r_la_ack = n; r_la_acks++; r_la_rd = la_rdat; end
      if (mem_en) begin en_cyc.push_back(n); en_we.push_back(mem_we); en_adr.push_back(mem_adr); end
      if (mem_we != 4'h0 && !mem_en) r_stray++;
      if (busy) r_busy = 1;
      @(posedge clk);
      #1;
      if (n == 0 && scramble) begin
        wbs_dat = $urandom; wbs_adr[23:0] = 24'($urandom); wbs_sel = 4'($urandom);
        wbs_we = 1'($urandom); la_adr = AW'($urandom); la_dat = $urandom; la_we = 1'($urandom);
      end
      if (wb_pend && (wbs_ack || n + 1 == drop_wb_at)) begin
        wb_pend = 0; wbs_cyc = 0; wbs_stb = 0;
      end
      if (la_pend && la_ack) begin la_pend = 0; la_req = 0; end
    end
    idle_inputs();
  endtask

  // Full transaction with model-derived expectations
  task automatic txn(input bit do_wb, input bit wb_we, input logic [31:0] wb_adr,
                     input logic [31:0] wb_dat, input logic [3:0] wb_sel,
                     input bit do_la, input bit la_w, input logic [AW-1:0] la_a,
                     input logic [31:0] la_d);
    bit wb_first;
    int e_wb, e_la, wa;
    logic [31:0] wb_rexp, la_rexp;
    logic [3:0] first_we;
    logic [AW-1:0] first_adr;
    wa = int'(wb_adr[AW+1:2]);
    if (do_wb && do_la) begin
`ifdef EXMEM_ARB_RR_EN
      wb_first = last_la;
`else
      wb_first = 1'b1;
`endif
    end else begin
      wb_first = do_wb;
    end
    e_wb = do_wb ? (wb_first ? LAT : 2*LAT + 1) : -1;
    e_la = do_la ? (wb_first ? 2*LAT + 1 : LAT) : -1;
    wb_rexp = '0; la_rexp = '0;
    if (wb_first) begin
      if (do_wb) wb_rexp = model_acc(wb_we, wa, wb_dat, wb_sel);
      if (do_la) la_rexp = model_acc(la_w, int'(la_a), la_d, 4'hF);
    end else begin
      if (do_la) la_rexp = model_acc(la_w, int'(la_a), la_d, 4'hF);
      if (do_wb) wb_rexp = model_acc(wb_we, wa, wb_dat, wb_sel);
    end
    first_we  = wb_first ? (wb_we ? wb_sel : 4'h0) : (la_w ? 4'hF : 4'h0);
    first_adr = wb_first ? wb_adr[AW+1:2] : la_a;
    if (do_wb && !wb_we) exp_q.push_back(wb_rexp);
    if (do_la && !la_w)  exp_q.push_back(la_rexp);

    run(do_wb, wb_we, wb_adr, wb_dat, wb_sel, do_la, la_w, la_a, la_d, -1, 40);

    chk("wb_ack_cycle", r_wb_ack, e_wb);
    chk("wb_ack_count", r_wb_acks, 32'(do_wb));
    chk("la_ack_cycle", r_la_ack, e_la);
    chk("la_ack_count", r_la_acks, 32'(do_la));
    if (do_wb && !wb_we) begin chk("wb_rdata", r_wb_rd, exp_q.pop_front()); exp_wb_dat = wb_rexp; end
    if (do_la && !la_w)  begin chk("la_rdata", r_la_rd, exp_q.pop_front()); exp_la_dat = la_rexp; end
    chk("mem_en_count", en_cyc.size(), 32'(do_wb) + 32'(do_la));
    if (en_cyc.size() > 0) begin
      chk("mem_en_cycle", en_cyc[0], LAT - 1);
      chk("mem_we_first", en_we[0], first_we);
      chk("mem_adr_first", en_adr[0], first_adr);
    end
    if (en_cyc.size() > 1) chk("mem_en_cycle2", en_cyc[1], 2*LAT);
    chk("stray_we", r_stray, 0);
    last_la = (do_wb && do_la) ? wb_first : do_la;
    chk("grant_o", grant, last_la);
    chk("busy_end", busy, 0);
    chk("wb_dat_hold", wbs_rdat, exp_wb_dat);
    chk("la_dat_hold", la_rdat, exp_la_dat);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int a;
    idle_inputs();
    mem_rdat = '0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 1);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_acks", {wbs_ack, la_ack}, 0);
    chk("rst_wb_dat", wbs_rdat, 0);
    rst_n = 1;
    @(posedge clk); #1;

    // Basic write, then read back through WB
    txn(1, 1, 32'h3800_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, '0, '0);
    txn(1, 0, 32'h3800_0010, 32'h0, 4'hF, 0, 0, '0, '0);

    // Outside the BRAM window: never acked, never busy
    run(1, 0, 32'h3000_0000, 32'h0, 4'hF, 0, 0, '0, '0, -1, 100);
    chk("bad_adr_ack", r_wb_acks, 0);
    chk("bad_adr_busy", r_busy, 0);
    chk("bad_adr_en", en_cyc.size(), 0);

    // Partial byte-lane write, then read back
    txn(1, 1, 32'h3800_0010, 32'h0000_ABCD, 4'b0011, 0, 0, '0, '0);
    txn(1, 0, 32'h3800_0010, 32'h0, 4'hF, 0, 0, '0, '0);

    // LA write and read
    txn(0, 0, '0, '0, '0, 1, 1, AW'(5), 32'h1234_5678);
    txn(0, 0, '0, '0, '0, 1, 0, AW'(5), 32'h0);

    // WB drops stb during WAIT: the write still lands, no ack
    void'(model_acc(1, 7, 32'hCAFE_F00D, 4'hF));
    run(1, 1, 32'h3800_001C, 32'hCAFE_F00D, 4'hF, 0, 0, '0, '0, 5, 40);
    chk("abort_ack", r_wb_acks, 0);
    chk("abort_en_count", en_cyc.size(), 1);
    if (en_cyc.size() > 0) chk("abort_en_cycle", en_cyc[0], LAT - 1);
    chk("abort_wb_dat", wbs_rdat, exp_wb_dat);
    last_la = 0;
    txn(1, 0, 32'h3800_001C, 32'h0, 4'hF, 0, 0, '0, '0);

    // Reset in the middle of WAIT
    wbs_cyc = 1; wbs_stb = 1; wbs_we = 1; wbs_sel = 4'hF;
    wbs_adr = 32'h3800_0020; wbs_dat = 32'h5555_AAAA;
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 0;
    @(negedge clk);
    chk("mid_rst_mem_en", mem_en, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_grant", grant, 1);
    chk("mid_rst_wb_dat", wbs_rdat, 0);
    chk("mid_rst_la_dat", la_rdat, 0);
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    exp_wb_dat = '0; exp_la_dat = '0; last_la = 1;
    run(0, 0, '0, '0, '0, 0, 0, '0, '0, -1, 30);
    chk("no_replay_ack", r_wb_acks + r_la_acks, 0);
    chk("no_replay_en", en_cyc.size(), 0);

    // Simultaneous requests, twice
    txn(1, 0, 32'h3800_0010, '0, 4'hF, 1, 0, AW'(5), '0);
    txn(1, 0, 32'h3800_0010, '0, 4'hF, 1, 0, AW'(5), '0);

    // Random mix over a small address range so reads hit earlier writes
    for (int i = 0; i < 25; i++) begin
      int kind;
      logic [31:0] wadr;
      kind = $urandom_range(0, 2);
      a = $urandom_range(0, 15);
      wadr = 32'h3800_0000 | (32'(a) << 2) | ($urandom & 32'h00FF_F003);
      txn(kind != 1, 1'($urandom), wadr, $urandom, 4'($urandom_range(1, 15)),
          kind != 0, 1'($urandom), AW'($urandom_range(0, 15)), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
